// File: rtl/shift_add_mult_pkg.sv
// mult_pkg: shared FSM state type and iteration-counter width helper for shift_add_mult.
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mult_state_t;
    function automatic int cnt_width(input int width);
        return $clog2(width);
    endfunction
endpackage

// File: rtl/shift_add_mult_if.sv
// shift_add_mult_if: multiplier handshake bundle.
//   start/sgn/a/b : request and operands, driven by the master
//   busy/done/product : status and full-width result, driven by the multiplier (slave)
interface shift_add_mult_if #(parameter int WIDTH = 16);
    logic                   start;
    logic                   sgn;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     product;
    modport master(output start, sgn, a, b, input busy, done, product);
    modport slave(input start, sgn, a, b, output busy, done, product);
endinterface

// File: rtl/shift_add_mult_abs.sv
// mult_abs: WIDTH-bit conditional absolute value.
//   value : operand; en : treat value as two's complement; mag : |value| when en, else value
// The most negative input maps to itself, which read as unsigned is its true magnitude.
module mult_abs #(parameter int WIDTH = 16) (
    input  logic [WIDTH-1:0] value,
    input  logic             en,
    output logic [WIDTH-1:0] mag
);
    assign mag = (en && value[WIDTH-1]) ? -value : value;
endmodule

// File: rtl/shift_add_mult.sv
// shift_add_mult: sequential shift-and-add multiplier, start/busy/done handshake.
//   clk, rst (sync, active-high); bus : shift_add_mult_if slave (start, sgn, a, b -> busy, done, product)
//   Optional macro SHIFT_ADD_MULT_EARLY_EXIT_EN: finish as soon as no multiplier bits remain.
module shift_add_mult
    import mult_pkg::*;
#(parameter int WIDTH = 16) (
    input  logic              clk,
    input  logic              rst,
    shift_add_mult_if.slave   bus
);
    localparam int CW = cnt_width(WIDTH);
    mult_state_t         state;
    logic [WIDTH-1:0]    a_mag, b_mag, mp, mp_next;
    logic [2*WIDTH-1:0]  mc, acc, acc_next;
    logic [CW-1:0]       cnt;
    logic                neg, last;
    mult_abs #(.WIDTH(WIDTH)) u_abs_a (.value(bus.a), .en(bus.sgn), .mag(a_mag));
    mult_abs #(.WIDTH(WIDTH)) u_abs_b (.value(bus.b), .en(bus.sgn), .mag(b_mag));
    assign acc_next = mp[0] ? acc + mc : acc;
    assign mp_next  = mp >> 1;
`ifdef SHIFT_ADD_MULT_EARLY_EXIT_EN
    assign last = (cnt == CW'(WIDTH - 1)) || (mp_next == '0);
`else
    assign last = cnt == CW'(WIDTH - 1);
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mc          <= '0;
            mp          <= '0;
            acc         <= '0;
            cnt         <= '0;
            neg         <= 1'b0;
            bus.busy    <= 1'b0;
            bus.done    <= 1'b0;
            bus.product <= '0;
        end else if (state == RUN) begin
            acc <= acc_next;
            mc  <= mc << 1;
            mp  <= mp_next;
            cnt <= cnt + 1'b1;
            if (last) begin
                state       <= DONE;
                bus.busy    <= 1'b0;
                bus.done    <= 1'b1;
                bus.product <= neg ? -acc_next : acc_next;
            end
        end else begin
            bus.done <= 1'b0;
            if (bus.start) begin
                state    <= RUN;
                bus.busy <= 1'b1;
                mc       <= {{WIDTH{1'b0}}, a_mag};
                mp       <= b_mag;
                neg      <= bus.sgn & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                acc      <= '0;
                cnt      <= '0;
            end else begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: doc/shift_add_mult.md
# shift_add_mult

Parametrised sequential shift-and-add multiplier with a start/busy/done handshake, synchronous reset and optional signed operation. It succeeds the fixed-width repeated-addition multiplier: latency is bounded by operand width rather than operand value, and the result is full-width. It sits between operand registers on the shared data path and any consumer that waits on `done`.

## Interface
- `WIDTH`, default 16: operand width in bits; must be ≥ 2.
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only when the block is idle or in DONE.
- `sgn`  in  1  sampled with `start`: 1 = operands are two's complement, 0 = unsigned.
- `a`  in  WIDTH  multiplicand, sampled with `start`.
- `b`  in  WIDTH  multiplier, sampled with `start`.
- `busy`  out  1  high while an operation is in RUN.
- `done`  out  1  one-cycle pulse; `product` is valid from this cycle.
- `product`  out  2*WIDTH  result register; holds until the next accepted `start`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE.
- IDLE/DONE + `start`=1 → RUN. Load `mc` = |a|, `mp` = |b| (magnitudes only when `sgn`=1), `neg` = sgn & (a[MSB] ^ b[MSB]), `acc` = 0, `cnt` = 0.
- `start` while `busy` is ignored entirely; inputs are not re-sampled.
- RUN, per cycle: if `mp[0]`, then `acc += mc`; `mc <<= 1` (2*WIDTH bits wide); `mp >>= 1`; `cnt++`.
- RUN exits to DONE on the edge completing iteration WIDTH (`cnt` = WIDTH-1). On that same edge, `product` ← `neg` ? −acc_next : acc_next (2*WIDTH-bit two's complement).
- DONE: `done`=1 for one cycle. Without `start` → IDLE. With `start` → RUN (back-to-back).
- Arithmetic: all accumulation is modulo 2^(2*WIDTH). No overflow is possible. The most negative operand, −2^(WIDTH-1), has magnitude 2^(WIDTH-1), which fits in WIDTH unsigned bits. (−2^(WIDTH-1))² = 2^(2*WIDTH-2) is representable.
- `sgn`=0: MSBs are ordinary magnitude bits and `neg`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `product`=0, state IDLE, internal registers 0.
- `start` sampled at edge E0. `busy` is high in cycles E0..E(WIDTH)−1. At edge E(WIDTH), `product` is updated, `done`=1 and `busy`=0 for that one cycle.
- Fixed latency: `done` follows the accepting edge by WIDTH edges (16 for the default).
- `rst` mid-operation: the edge it is sampled on forces IDLE with all outputs at reset values. No `done` pulse follows, and the partial result is discarded.
- `rst` and `start` on the same edge: reset wins.
- Back-to-back: `start` in the DONE cycle gives zero idle cycles between operations.

## Configuration
- `SHIFT_ADD_MULT_EARLY_EXIT_EN` defined: RUN also exits on the edge where `mp_next`=0.
  - `product` and `done` then follow that edge, so latency = max(1, index of highest set bit of |b| + 1) edges.
  - Result is identical to the fixed-latency case.
- Not defined: latency is always exactly WIDTH edges, independent of data.

## Structure
- Shared package `mult_pkg`: the state enum `mult_state_t` (IDLE, RUN, DONE) and the iteration-count width function `$clog2(WIDTH)`.
- One sub-module, `mult_abs`: WIDTH-bit conditional two's-complement absolute value (inputs value and `en`). Instantiate it twice, for `a` and `b`.
- The final negation is inline.

## Test plan
1. Unsigned 3 × 5, WIDTH=16 → `product`=15 (0x0000000F), `done` exactly 16 edges after `start`, `busy` high for 16 cycles.
2. Unsigned 0xFFFF × 0xFFFF → 0xFFFE0001. Signed (`sgn`=1) 0xFFFF × 0xFFFF (−1 × −1) → 0x00000001.
3. Signed −3 × 7 → 0xFFFFFFEB. Signed 0x8000 × 0x8000 → 0x40000000. Signed 0x8000 × 0x0001 → 0xFFFF8000.
4. Handshake robustness:
   - `start` pulsed with new operands at the 5th busy cycle → ignored; first result is unchanged.
   - `start` held in the DONE cycle → second operation begins with no idle cycle.
5. Reset robustness:
   - `rst` at the 8th busy cycle → next cycle `busy`=0, `product`=0; no `done` appears within 20 cycles.
   - A following 2 × 2 → 4.
6. With `SHIFT_ADD_MULT_EARLY_EXIT_EN`:
   - 9 × 1 → `done` 1 edge after `start`.
   - 9 × 0 → product 0 after 1 edge.
   - 9 × 0x0100 → 0x900 after 9 edges.
   - Without the macro, all three take 16 edges.
